// File: rtl/alu_if.sv
// Operand, control and result signals of the execute-stage ALU.
// No handshake: the master presents one operation every cycle and reads Out/Flags one cycle later.
interface alu_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] In1;
    logic [WIDTH-1:0] In2;
    logic [15:0]      Immediate;
    logic [3:0]       Opcode;
    logic [3:0]       Cond;
    logic [2:0]       SR_Cont;
    logic [4:0]       SR_Bit;
    logic             S;
    logic [WIDTH-1:0] Out;
    logic [3:0]       Flags;

    modport master (
        output In1, In2, Immediate, Opcode, Cond, SR_Cont, SR_Bit, S,
        input  Out, Flags
    );

    modport slave (
        input  In1, In2, Immediate, Opcode, Cond, SR_Cont, SR_Bit, S,
        output Out, Flags
    );
endinterface

// File: rtl/alu_core.sv
// Registered 32-bit ALU with a barrel-shifted second operand and NZCV flags.
// The condition code is checked against the current flags; a failed condition holds Out and Flags.
module alu_core #(
    parameter int WIDTH = 32
) (
    input  logic  clk,
    input  logic  rst,
    alu_if.slave  bus
);
    logic [WIDTH-1:0]   out_q;
    logic [3:0]         flags_q;
    logic               n_flag, z_flag, c_flag, v_flag;
    logic [WIDTH-1:0]   imm_ext;
    logic [WIDTH-1:0]   op2;
    logic               sh_c;
    logic [2*WIDTH-1:0] rot;
    logic [4:0]         lsl_idx, rsh_idx;
    logic [WIDTH-1:0]   add_a, add_b, result;
    logic               add_cin, is_arith, is_cmp, cond_pass;
    logic [WIDTH:0]     sum;
    logic [3:0]         new_flags;

    assign {n_flag, z_flag, c_flag, v_flag} = flags_q;
    assign imm_ext = {{(WIDTH-16){1'b0}}, bus.Immediate};
    // For n > 0, 32-n and n-1 both fit in five bits.
    assign lsl_idx = 5'd0 - bus.SR_Bit;
    assign rsh_idx = bus.SR_Bit - 5'd1;

    always_comb begin
        op2  = bus.In2;
        sh_c = c_flag;
        rot  = '0;
        case (bus.SR_Cont)
            3'b001: if (bus.SR_Bit != 5'd0) begin
                op2  = bus.In2 << bus.SR_Bit;
                sh_c = bus.In2[lsl_idx];
            end
            3'b010: if (bus.SR_Bit != 5'd0) begin
                op2  = bus.In2 >> bus.SR_Bit;
                sh_c = bus.In2[rsh_idx];
            end
            3'b011: if (bus.SR_Bit != 5'd0) begin
                op2  = WIDTH'($signed(bus.In2) >>> bus.SR_Bit);
                sh_c = bus.In2[rsh_idx];
            end
            3'b100: if (bus.SR_Bit != 5'd0) begin
                rot  = {bus.In2, bus.In2} >> bus.SR_Bit;
                op2  = rot[WIDTH-1:0];
                sh_c = rot[WIDTH-1];
            end
            3'b101: begin
                op2  = {c_flag, bus.In2[WIDTH-1:1]};
                sh_c = bus.In2[0];
            end
            3'b110: op2 = imm_ext;
            3'b111: begin
                op2 = imm_ext;
                if (bus.SR_Bit != 5'd0) begin
                    rot  = {imm_ext, imm_ext} >> bus.SR_Bit;
                    op2  = rot[WIDTH-1:0];
                    sh_c = rot[WIDTH-1];
                end
            end
            default: ;
        endcase
    end

    // All arithmetic goes through one adder; subtraction is A + ~B + carry-in.
    always_comb begin
        add_a    = bus.In1;
        add_b    = op2;
        add_cin  = 1'b0;
        is_arith = 1'b1;
        case (bus.Opcode)
            4'b0010, 4'b1011: begin add_b = ~op2; add_cin = 1'b1; end
            4'b0011: begin add_a = op2; add_b = ~bus.In1; add_cin = 1'b1; end
            4'b0100, 4'b1010: ;
            4'b0101: add_cin = c_flag;
            4'b0110: begin add_b = ~op2; add_cin = c_flag; end
            4'b0111: begin add_a = op2; add_b = ~bus.In1; add_cin = c_flag; end
            default: is_arith = 1'b0;
        endcase
    end

    assign sum = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};

    always_comb begin
        result = sum[WIDTH-1:0];
        case (bus.Opcode)
            4'b0000, 4'b1000: result = bus.In1 & op2;
            4'b0001, 4'b1001: result = bus.In1 ^ op2;
            4'b1100:          result = bus.In1 | op2;
            4'b1101:          result = op2;
            4'b1110:          result = bus.In1 & ~op2;
            4'b1111:          result = ~op2;
            default: ;
        endcase
    end

    always_comb begin
        new_flags[3] = result[WIDTH-1];
        new_flags[2] = (result == '0);
        new_flags[1] = is_arith ? sum[WIDTH] : sh_c;
        new_flags[0] = is_arith ? ((add_a[WIDTH-1] == add_b[WIDTH-1]) &&
                                   (result[WIDTH-1] != add_a[WIDTH-1])) : v_flag;
    end

    always_comb begin
        cond_pass = 1'b0;
        case (bus.Cond)
            4'b0000: cond_pass = 1'b1;
            4'b0001: cond_pass = z_flag;
            4'b0010: cond_pass = !z_flag;
            4'b0011: cond_pass = c_flag;
            4'b0100: cond_pass = !c_flag;
            4'b0101: cond_pass = n_flag;
            4'b0110: cond_pass = !n_flag;
            4'b0111: cond_pass = v_flag;
            4'b1000: cond_pass = !v_flag;
            4'b1001: cond_pass = c_flag && !z_flag;
            4'b1010: cond_pass = !c_flag || z_flag;
            4'b1011: cond_pass = (n_flag == v_flag);
            4'b1100: cond_pass = (n_flag != v_flag);
            4'b1101: cond_pass = !z_flag && (n_flag == v_flag);
            4'b1110: cond_pass = z_flag || (n_flag != v_flag);
            default: cond_pass = 1'b0;
        endcase
    end

    assign is_cmp = (bus.Opcode[3:2] == 2'b10);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q   <= '0;
            flags_q <= 4'b0000;
        end else if (cond_pass) begin
            out_q <= result;
            if (is_cmp || bus.S) flags_q <= new_flags;
        end
    end

    assign bus.Out   = out_q;
    assign bus.Flags = flags_q;
endmodule

// File: tb/tb_alu_core.sv
// Scoreboard bench for alu_core: a reference model predicts Out/Flags per driven operation,
// and results are popped and compared one cycle later on the falling edge.
module tb_alu_core;
    logic clk;
    logic rst;
    alu_if #(.WIDTH(32)) bus ();

    alu_core #(.WIDTH(32)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [35:0] exp_q[$];
    string       tag_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] m_out = '0;
    logic [3:0]  m_flags = '0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic model_step(input logic r, input logic [31:0] a, input logic [31:0] b,
                              input logic [15:0] imm, input logic [3:0] op, input logic [3:0] cond,
                              input logic [2:0] src, input logic [4:0] n, input logic s);
        logic [63:0] t;
        logic [63:0] u;
        logic [31:0] op2, res, x, y;
        logic        shc, pass, nf, zf, cf, vf, c, v, cin, brw, is_add, is_sub;
        longint      sv;
        longint      lim;
        lim = 64'sh80000000;
        {nf, zf, cf, vf} = m_flags;
        if (r) begin
            m_out = '0;
            m_flags = '0;
            return;
        end
        case (cond)
            4'd0:  pass = 1'b1;
            4'd1:  pass = zf;
            4'd2:  pass = !zf;
            4'd3:  pass = cf;
            4'd4:  pass = !cf;
            4'd5:  pass = nf;
            4'd6:  pass = !nf;
            4'd7:  pass = vf;
            4'd8:  pass = !vf;
            4'd9:  pass = cf && !zf;
            4'd10: pass = !cf || zf;
            4'd11: pass = (nf == vf);
            4'd12: pass = (nf != vf);
            4'd13: pass = !zf && (nf == vf);
            4'd14: pass = zf || (nf != vf);
            default: pass = 1'b0;
        endcase
        if (!pass) return;
        op2 = b;
        shc = cf;
        case (src)
            3'd1: if (n != 0) begin t = {32'h0, b} << n; op2 = t[31:0]; shc = t[32]; end
            3'd2: if (n != 0) begin t = {b, 32'h0} >> n; op2 = t[63:32]; shc = t[31]; end
            3'd3: if (n != 0) begin t = 64'($signed({b, 32'h0}) >>> n); op2 = t[63:32]; shc = t[31]; end
            3'd4: if (n != 0) begin t = {b, b} >> n; op2 = t[31:0]; shc = op2[31]; end
            3'd5: begin op2 = {cf, b[31:1]}; shc = b[0]; end
            3'd6: op2 = {16'h0, imm};
            3'd7: begin
                op2 = {16'h0, imm};
                if (n != 0) begin t = {op2, op2} >> n; op2 = t[31:0]; shc = op2[31]; end
            end
            default: ;
        endcase
        is_add = 1'b0; is_sub = 1'b0; x = a; y = op2; cin = 1'b0; brw = 1'b0; res = '0;
        case (op)
            4'd0, 4'd8:  res = a & op2;
            4'd1, 4'd9:  res = a ^ op2;
            4'd2, 4'd11: is_sub = 1'b1;
            4'd3:        begin is_sub = 1'b1; x = op2; y = a; end
            4'd4, 4'd10: is_add = 1'b1;
            4'd5:        begin is_add = 1'b1; cin = cf; end
            4'd6:        begin is_sub = 1'b1; brw = !cf; end
            4'd7:        begin is_sub = 1'b1; x = op2; y = a; brw = !cf; end
            4'd12:       res = a | op2;
            4'd13:       res = op2;
            4'd14:       res = a & ~op2;
            default:     res = ~op2;
        endcase
        c = shc;
        v = vf;
        if (is_add) begin
            u = {32'h0, x} + {32'h0, y} + 64'(cin);
            res = u[31:0];
            c = u[32];
            sv = longint'($signed(x)) + longint'($signed(y)) + longint'(cin);
            v = (sv >= lim) || (sv < -lim);
        end else if (is_sub) begin
            res = x - y - 32'(brw);
            c = ({32'h0, x} >= ({32'h0, y} + 64'(brw)));
            sv = longint'($signed(x)) - longint'($signed(y)) - longint'(brw);
            v = (sv >= lim) || (sv < -lim);
        end
        m_out = res;
        if (op[3:2] == 2'b10 || s) m_flags = {res[31], res == 32'h0, c, v};
    endtask

    task automatic collect();
        logic [35:0] e;
        string t;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check_val({t, " out"}, bus.Out, e[35:4]);
            check_val({t, " flags"}, {28'h0, bus.Flags}, {28'h0, e[3:0]});
        end
    endtask

    task automatic apply(input string tag, input logic r, input logic [31:0] a, input logic [31:0] b,
                         input logic [15:0] imm, input logic [3:0] op, input logic [3:0] cond,
                         input logic [2:0] src, input logic [4:0] n, input logic s);
        @(negedge clk);
        collect();
        rst = r;
        bus.In1 = a; bus.In2 = b; bus.Immediate = imm; bus.Opcode = op;
        bus.Cond = cond; bus.SR_Cont = src; bus.SR_Bit = n; bus.S = s;
        model_step(r, a, b, imm, op, cond, src, n, s);
        exp_q.push_back({m_out, m_flags});
        tag_q.push_back(tag);
    endtask

    initial begin
        rst = 1'b1;
        bus.In1 = '0; bus.In2 = '0; bus.Immediate = '0; bus.Opcode = '0;
        bus.Cond = '0; bus.SR_Cont = '0; bus.SR_Bit = '0; bus.S = 1'b0;

        apply("reset0", 1'b1, 32'h0, 32'h0, 16'h0, 4'h0, 4'h0, 3'd0, 5'd0, 1'b0);
        apply("reset1", 1'b1, 32'h0, 32'h0, 16'h0, 4'h0, 4'h0, 3'd0, 5'd0, 1'b0);

        apply("cmp_15_20", 1'b0, 32'd15, 32'd20, 16'h0, 4'b1011, 4'h0, 3'd0, 5'd5, 1'b1);
        apply("cmp_5_5",   1'b0, 32'd5,  32'd5,  16'h0, 4'b1011, 4'h0, 3'd0, 5'd5, 1'b1);
        apply("cmp_30_25", 1'b0, 32'd30, 32'd25, 16'h0, 4'b1011, 4'h0, 3'd0, 5'd5, 1'b1);
        apply("cmp_ovf",   1'b0, 32'd0,  32'h80000000, 16'h0, 4'b1011, 4'h0, 3'd0, 5'd5, 1'b1);

        apply("add_s0", 1'b0, 32'hFFFFFFFF, 32'd1, 16'h0, 4'b0100, 4'h0, 3'd0, 5'd0, 1'b0);
        apply("add_s1", 1'b0, 32'hFFFFFFFF, 32'd1, 16'h0, 4'b0100, 4'h0, 3'd0, 5'd0, 1'b1);

        apply("mov_lsr", 1'b0, 32'h0, 32'h000000F8, 16'h0, 4'b1101, 4'h0, 3'd2, 5'd4, 1'b1);
        apply("mov_imm", 1'b0, 32'h0, 32'h0, 16'hBEEF, 4'b1101, 4'h0, 3'd6, 5'd0, 1'b1);

        apply("add_eq_skip", 1'b0, 32'd7, 32'd9, 16'h0, 4'b0100, 4'b0001, 3'd0, 5'd0, 1'b1);
        apply("add_ne_exec", 1'b0, 32'd7, 32'd9, 16'h0, 4'b0100, 4'b0010, 3'd0, 5'd0, 1'b1);

        apply("lsl_31", 1'b0, 32'd0, 32'h00000003, 16'h0, 4'b1101, 4'h0, 3'd1, 5'd31, 1'b1);
        apply("asr_1",  1'b0, 32'd0, 32'h80000001, 16'h0, 4'b1101, 4'h0, 3'd3, 5'd1, 1'b1);
        apply("rrx",    1'b0, 32'd0, 32'h00000001, 16'h0, 4'b1101, 4'h0, 3'd5, 5'd9, 1'b1);
        apply("cmp_nv", 1'b0, 32'd1, 32'd2, 16'h0, 4'b1011, 4'b1111, 3'd0, 5'd0, 1'b1);

        apply("cmp_rst", 1'b1, 32'd15, 32'd20, 16'h0, 4'b1011, 4'h0, 3'd0, 5'd5, 1'b1);

        for (int i = 0; i < 300; i++) begin
            apply("rand",
                  ($urandom_range(0, 24) == 0),
                  ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom,
                  ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : $urandom,
                  16'($urandom),
                  4'($urandom_range(0, 15)),
                  ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'h0,
                  3'($urandom_range(0, 7)),
                  ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                  1'($urandom_range(0, 1)));
        end

        @(negedge clk);
        collect();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
